// File: rtl/axis_frame_arbiter_pkg.sv
// Shared types and helpers for the frame-granular AXI-Stream arbiter:
// FSM state encoding, counter width helper and the round-robin picker.
package axis_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int MAX_INPUTS = 32;
  localparam int PICK_IDX_W = $clog2(MAX_INPUTS);

  typedef logic [MAX_INPUTS-1:0] req_vec_t;

  function automatic int cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

  // One-hot pick of the first requester strictly after the one-hot 'last',
  // wrapping modulo n; only the low n bits of req/last are meaningful.
  function automatic req_vec_t rr_pick(input req_vec_t req, input req_vec_t last, input int n);
    req_vec_t pick;
    int       last_idx;
    int       idx;
    logic     found;
    pick     = '0;
    last_idx = n - 1;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < MAX_INPUTS; i++) begin
      if (i < n && last[i]) last_idx = i;
    end
    for (int k = 1; k <= MAX_INPUTS; k++) begin
      if (k <= n) begin
        idx = last_idx + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[PICK_IDX_W-1:0]]) begin
          pick[idx[PICK_IDX_W-1:0]] = 1'b1;
          found                     = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_frame_arbiter_if.sv
// Multi-lane AXI-Stream bundle: LANES parallel streams with packed tdata
// (lane i = tdata[i*DATA_WIDTH +: DATA_WIDTH]) and per-lane sideband bits.
interface axis_frame_arbiter_if #(
  parameter int LANES      = 1,
  parameter int DATA_WIDTH = 8
);
  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic [LANES-1:0]            tlast;
  logic [LANES-1:0]            tuser;
  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            trdy;

  modport master (output tdata, tlast, tuser, tvalid, input trdy);
  modport slave  (input tdata, tlast, tuser, tvalid, output trdy);
endinterface

// File: rtl/axis_frame_arbiter_skid.sv
// Two-entry registered output slice. in_ready depends only on the fill
// level register, so there is no combinational path from out_ready.
module axis_skid_buffer #(
  parameter int WIDTH = 10
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  // NOTE: non-blocking (<=) for all clocked state so every flop samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage is not reset; count alone decides what is valid.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin merge of NUM_INPUTS AXI-Stream sources onto one
// output; grant held to tlast, overlong frames truncated and flagged in tuser.
module axis_frame_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_INPUTS      = 4,
  parameter int AXI_DATA_WIDTH  = 8,
  parameter int MAX_FRAME_BEATS = 1518
) (
  input  logic                  aclk,
  input  logic                  areset,
  axis_frame_arbiter_if.slave   s_axis,
  axis_frame_arbiter_if.master  m_axis,
  output logic [NUM_INPUTS-1:0] grant,
  output logic                  trunc_pulse
);

  localparam int CNT_W  = cnt_width(MAX_FRAME_BEATS);
  localparam int SKID_W = AXI_DATA_WIDTH + 2;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_XFER  = XFER;
  localparam logic [1:0] S_DRAIN = DRAIN;

  localparam logic [CNT_W-1:0]      LAST_BEAT      = CNT_W'(MAX_FRAME_BEATS - 1);
  localparam logic [CNT_W-1:0]      CNT_SAT        = CNT_W'(MAX_FRAME_BEATS);
  localparam logic [NUM_INPUTS-1:0] LAST_GRANT_RST = {1'b1, {(NUM_INPUTS-1){1'b0}}};

  logic [1:0]                state;
  logic [NUM_INPUTS-1:0]     last_grant;
  logic [NUM_INPUTS-1:0]     pick;
  logic [CNT_W-1:0]          beat_cnt;
  logic [CNT_W-1:0]          cnt_inc;
  logic [AXI_DATA_WIDTH-1:0] sel_data;
  logic                      sel_valid;
  logic                      sel_last;
  logic                      sel_user;
  logic                      lane_ready;
  logic                      accept;
  logic                      push;
  logic                      trunc;
  logic                      skid_ready;
  logic                      skid_valid;
  logic [SKID_W-1:0]         skid_in;
  logic [SKID_W-1:0]         skid_out;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) begin
        sel_data  = s_axis.tdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        sel_valid = s_axis.tvalid[i];
        sel_last  = s_axis.tlast[i];
        sel_user  = s_axis.tuser[i];
      end
    end
  end

  assign pick = NUM_INPUTS'(rr_pick(MAX_INPUTS'(s_axis.tvalid), MAX_INPUTS'(last_grant), NUM_INPUTS));

  // Ready is built only from registers: FSM state, grant and the skid fill level.
  assign lane_ready  = (state == S_XFER && skid_ready) || (state == S_DRAIN);
  assign s_axis.trdy = grant & {NUM_INPUTS{lane_ready}};
  assign accept      = sel_valid & lane_ready;
  assign push        = accept & (state == S_XFER);
  assign trunc       = push & ~sel_last & (beat_cnt == LAST_BEAT);
  assign cnt_inc     = (beat_cnt == CNT_SAT) ? beat_cnt : beat_cnt + CNT_W'(1);
  assign skid_in     = {sel_data, sel_last | trunc, trunc | (sel_user & sel_last)};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= S_IDLE;
      grant       <= '0;
      last_grant  <= LAST_GRANT_RST;
      beat_cnt    <= '0;
      trunc_pulse <= 1'b0;
    end else begin
      trunc_pulse <= trunc;
      case (state)
        S_IDLE: begin
          if (|s_axis.tvalid) begin
            grant <= pick;
            state <= S_XFER;
          end
        end
        S_XFER, S_DRAIN: begin
          if (accept) begin
            if (sel_last) begin
              state      <= S_IDLE;
              grant      <= '0;
              last_grant <= grant;
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= cnt_inc;
              if (trunc) state <= S_DRAIN;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  axis_skid_buffer #(
    .WIDTH (SKID_W)
  ) u_skid (
    .aclk      (aclk),
    .areset    (areset),
    .in_data   (skid_in),
    .in_valid  (push),
    .in_ready  (skid_ready),
    .out_data  (skid_out),
    .out_valid (skid_valid),
    .out_ready (m_axis.trdy[0])
  );

  assign m_axis.tdata  = skid_out[SKID_W-1:2];
  assign m_axis.tlast  = skid_out[1];
  assign m_axis.tuser  = skid_out[0];
  assign m_axis.tvalid = skid_valid;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Scoreboard bench for axis_frame_arbiter with a short frame limit (4 beats)
// so truncation is reachable; sources hold each beat until it is accepted.
module tb_axis_frame_arbiter;

  localparam int NUM_INPUTS = 4;
  localparam int DATA_W     = 8;
  localparam int MAX_BEATS  = 4;
  localparam int BUDGET     = 200;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              user;
  } beat_t;

  typedef struct {
    int    lane;
    beat_t beat;
  } src_t;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] data;
  } stall_t;

  logic                  aclk;
  logic                  areset;
  logic [NUM_INPUTS-1:0] grant;
  logic                  trunc_pulse;

  axis_frame_arbiter_if #(.LANES(NUM_INPUTS), .DATA_WIDTH(DATA_W)) s_axis ();
  axis_frame_arbiter_if #(.LANES(1),          .DATA_WIDTH(DATA_W)) m_axis ();

  axis_frame_arbiter #(
    .NUM_INPUTS      (NUM_INPUTS),
    .AXI_DATA_WIDTH  (DATA_W),
    .MAX_FRAME_BEATS (MAX_BEATS)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .s_axis      (s_axis),
    .m_axis      (m_axis),
    .grant       (grant),
    .trunc_pulse (trunc_pulse)
  );

  src_t   src_q[$];
  beat_t  exp_q[$];
  beat_t  obs_q[$];
  stall_t stall_q[$];
  logic   rdy_q[$];
  int     n_checks  = 0;
  int     n_fail    = 0;
  int     trunc_cnt = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Queue a frame at a source and, from the bench's own model, its expected output beats.
  // Frames are loaded in the order the round-robin arbiter must emit them.
  task automatic load_frame(input int lane, input logic [DATA_W-1:0] base, input int beats,
                            input logic user);
    src_t  s;
    beat_t e;
    for (int k = 1; k <= beats; k++) begin
      s.lane      = lane;
      s.beat.data = base + DATA_W'(k - 1);
      s.beat.last = (k == beats);
      s.beat.user = user;
      src_q.push_back(s);
      if (k <= MAX_BEATS) begin
        e.data = s.beat.data;
        e.last = (k == beats) || (k == MAX_BEATS);
        e.user = (k == beats) ? user : (k == MAX_BEATS);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive_inputs();
    logic [NUM_INPUTS*DATA_W-1:0] d;
    logic [NUM_INPUTS-1:0]        v;
    logic [NUM_INPUTS-1:0]        l;
    logic [NUM_INPUTS-1:0]        u;
    bit                           found;
    d = '0; v = '0; l = '0; u = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      found = 1'b0;
      for (int j = 0; j < src_q.size(); j++) begin
        if (!found && src_q[j].lane == i) begin
          found                  = 1'b1;
          d[i*DATA_W +: DATA_W]  = src_q[j].beat.data;
          v[i]                   = 1'b1;
          l[i]                   = src_q[j].beat.last;
          u[i]                   = src_q[j].beat.user;
        end
      end
    end
    s_axis.tdata  = d;
    s_axis.tvalid = v;
    s_axis.tlast  = l;
    s_axis.tuser  = u;
    if (rdy_q.size() != 0) m_axis.trdy = rdy_q.pop_front();
    else                   m_axis.trdy = 1'b1;
  endtask

  // Sample on the falling edge, then drive new inputs 1 time unit after the rising edge.
  task automatic tick();
    stall_t st;
    bit     done;
    @(negedge aclk);
    if (m_axis.tvalid[0] && m_axis.trdy[0]) begin
      obs_q.push_back(beat_t'{m_axis.tdata, m_axis.tlast[0], m_axis.tuser[0]});
    end else if (m_axis.tvalid[0]) begin
      st.idx  = obs_q.size();
      st.data = m_axis.tdata;
      stall_q.push_back(st);
    end
    if (trunc_pulse) trunc_cnt++;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (s_axis.tvalid[i] && s_axis.trdy[i]) begin
        done = 1'b0;
        for (int j = 0; j < src_q.size(); j++) begin
          if (!done && src_q[j].lane == i) begin
            src_q.delete(j);
            done = 1'b1;
          end
        end
      end
    end
    @(posedge aclk);
    #1;
    drive_inputs();
  endtask

  task automatic run_until_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      if (src_q.size() == 0 && obs_q.size() >= exp_q.size() && !m_axis.tvalid[0] && grant == '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    drive_inputs();
    repeat (3) tick();
    n_checks++; if (m_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid: got %b want 0", m_axis.tvalid); end
    n_checks++; if (m_axis.tlast !== 1'b0)  begin n_fail++; $display("FAIL rst_m_tlast: got %b want 0", m_axis.tlast); end
    n_checks++; if (m_axis.tuser !== 1'b0)  begin n_fail++; $display("FAIL rst_m_tuser: got %b want 0", m_axis.tuser); end
    n_checks++; if (s_axis.trdy !== 4'b0)   begin n_fail++; $display("FAIL rst_s_trdy: got %b want 0000", s_axis.trdy); end
    n_checks++; if (grant !== 4'b0)         begin n_fail++; $display("FAIL rst_grant: got %b want 0000", grant); end
    n_checks++; if (trunc_pulse !== 1'b0)   begin n_fail++; $display("FAIL rst_trunc: got %b want 0", trunc_pulse); end
    areset = 1'b0;
    repeat (3) tick();
    n_checks++; if (grant !== 4'b0)         begin n_fail++; $display("FAIL idle_grant: got %b want 0000", grant); end
    n_checks++; if (s_axis.trdy !== 4'b0)   begin n_fail++; $display("FAIL idle_s_trdy: got %b want 0000", s_axis.trdy); end
  endtask

  task automatic test_single_frame();
    bit    ok;
    beat_t e, o;
    load_frame(0, 8'hA1, 3, 1'b0);
    drive_inputs();
    tick();
    n_checks++; if (grant !== 4'b0001)        begin n_fail++; $display("FAIL t1_grant: got %b want 0001", grant); end
    n_checks++; if (m_axis.tvalid !== 1'b0)   begin n_fail++; $display("FAIL t1_early_tvalid: got %b want 0", m_axis.tvalid); end
    tick();
    n_checks++; if (m_axis.tvalid !== 1'b1)   begin n_fail++; $display("FAIL t1_latency: got tvalid %b want 1", m_axis.tvalid); end
    n_checks++; if (m_axis.tdata !== 8'hA1)   begin n_fail++; $display("FAIL t1_first_data: got %h want a1", m_axis.tdata); end
    run_until_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t1_timeout: got busy want idle within %0d cycles", BUDGET); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t1_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL t1_beat: got %h/%b/%b want %h/%b/%b", o.data, o.last, o.user, e.data, e.last, e.user); end
    end
    exp_q.delete(); obs_q.delete(); stall_q.delete();
  endtask

  task automatic test_round_robin();
    bit    ok;
    beat_t e, o;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    tick();
    load_frame(0, 8'h10, 2, 1'b0);
    load_frame(1, 8'h20, 2, 1'b0);
    load_frame(2, 8'h30, 2, 1'b0);
    drive_inputs();
    tick();
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL t2_first_grant: got %b want 0001", grant); end
    run_until_idle(ok);
    load_frame(3, 8'h40, 2, 1'b0);
    load_frame(1, 8'h50, 2, 1'b0);
    drive_inputs();
    tick();
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL t2_rr_grant: got %b want 1000", grant); end
    run_until_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t2_timeout: got busy want idle within %0d cycles", BUDGET); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t2_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL t2_order: got %h/%b/%b want %h/%b/%b", o.data, o.last, o.user, e.data, e.last, e.user); end
    end
    exp_q.delete(); obs_q.delete(); stall_q.delete();
  endtask

  task automatic test_backpressure();
    bit    ok;
    beat_t e, o;
    for (int i = 0; i < 24; i++) rdy_q.push_back(i % 2 == 0);
    load_frame(1, 8'h60, 4, 1'b0);
    drive_inputs();
    run_until_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t3_timeout: got busy want idle within %0d cycles", BUDGET); end
    n_checks++; if (stall_q.size() == 0) begin n_fail++; $display("FAIL t3_stalls: got 0 stalled cycles want at least 1"); end
    foreach (stall_q[i]) begin
      n_checks++;
      if (stall_q[i].idx >= exp_q.size()) begin
        n_fail++; $display("FAIL t3_stall_extra: got stalled beat %0d want at most %0d beats", stall_q[i].idx, exp_q.size());
      end else if (stall_q[i].data !== exp_q[stall_q[i].idx].data) begin
        n_fail++; $display("FAIL t3_stall_data: got %h want %h", stall_q[i].data, exp_q[stall_q[i].idx].data);
      end
    end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t3_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL t3_beat: got %h/%b/%b want %h/%b/%b", o.data, o.last, o.user, e.data, e.last, e.user); end
    end
    exp_q.delete(); obs_q.delete(); stall_q.delete(); rdy_q.delete();
  endtask

  task automatic test_truncation();
    bit    ok;
    beat_t e, o;
    trunc_cnt = 0;
    load_frame(2, 8'h70, 6, 1'b0);
    drive_inputs();
    run_until_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t4_timeout: got busy want idle within %0d cycles", BUDGET); end
    n_checks++; if (trunc_cnt != 1) begin n_fail++; $display("FAIL t4_trunc_pulse: got %0d pulses want 1", trunc_cnt); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t4_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL t4_beat: got %h/%b/%b want %h/%b/%b", o.data, o.last, o.user, e.data, e.last, e.user); end
    end
    exp_q.delete(); obs_q.delete(); stall_q.delete();
  endtask

  task automatic test_tuser_passthrough();
    bit    ok;
    beat_t e, o;
    trunc_cnt = 0;
    load_frame(3, 8'h80, 4, 1'b1);
    load_frame(3, 8'h90, 4, 1'b0);
    drive_inputs();
    run_until_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t5_timeout: got busy want idle within %0d cycles", BUDGET); end
    n_checks++; if (trunc_cnt != 0) begin n_fail++; $display("FAIL t5_trunc_pulse: got %0d pulses want 0", trunc_cnt); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t5_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL t5_beat: got %h/%b/%b want %h/%b/%b", o.data, o.last, o.user, e.data, e.last, e.user); end
    end
    exp_q.delete(); obs_q.delete(); stall_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    bit    ok;
    beat_t e, o;
    load_frame(2, 8'hB0, 4, 1'b0);
    drive_inputs();
    repeat (3) tick();
    n_checks++; if (m_axis.tvalid !== 1'b1) begin n_fail++; $display("FAIL t6_mid_frame: got tvalid %b want 1", m_axis.tvalid); end
    areset = 1'b1;
    #1;
    n_checks++; if (m_axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL t6_abort_tvalid: got %b want 0", m_axis.tvalid); end
    n_checks++; if (s_axis.trdy !== 4'b0)   begin n_fail++; $display("FAIL t6_abort_s_trdy: got %b want 0000", s_axis.trdy); end
    n_checks++; if (grant !== 4'b0)         begin n_fail++; $display("FAIL t6_abort_grant: got %b want 0000", grant); end
    src_q.delete(); exp_q.delete(); obs_q.delete(); stall_q.delete();
    drive_inputs();
    repeat (2) tick();
    areset = 1'b0;
    tick();
    load_frame(0, 8'hC0, 2, 1'b0);
    load_frame(2, 8'hD0, 2, 1'b0);
    drive_inputs();
    tick();
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL t6_first_after_reset: got %b want 0001", grant); end
    run_until_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t6_timeout: got busy want idle within %0d cycles", BUDGET); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t6_count: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL t6_beat: got %h/%b/%b want %h/%b/%b", o.data, o.last, o.user, e.data, e.last, e.user); end
    end
    exp_q.delete(); obs_q.delete(); stall_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_tuser_passthrough();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
